uart_tx_arbiter: RTL and testbench

Shares one uart_ctrl transmitter between NREQ byte requesters using round-robin arbitration. Each grant latches the winner's byte and issues a one-cycle write strobe to uart_ctrl. The block then tracks the UART busy flag and returns a one-cycle ack to the winner when the byte has left the line. It sits between the CPU/peripheral byte sources and uart_ctrl.

---
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the round-robin arbiter and uart_ctrl.
// The lock vector exists only when UART_ARB_LOCK_EN is defined.
interface uart_tx_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   ack;
   logic              grant_valid;
   logic [IDX_W-1:0]  grant_idx;
   logic [7:0]        uart_byte;
   logic              uart_we;
   logic              uart_busy;
`ifdef UART_ARB_LOCK_EN
   logic [NREQ-1:0]   lock;
`endif

   // Requesters plus the uart_ctrl busy flag drive the arbiter.
   modport master (
      output req, req_data, uart_busy,
`ifdef UART_ARB_LOCK_EN
      output lock,
`endif
      input  ack, grant_valid, grant_idx, uart_byte, uart_we
   );

   modport slave (
      input  req, req_data, uart_busy,
`ifdef UART_ARB_LOCK_EN
      input  lock,
`endif
      output ack, grant_valid, grant_idx, uart_byte, uart_we
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_ctrl transmitter among NREQ byte requesters.
// Optional UART_ARB_LOCK_EN keeps the grant on one requester while its lock bit is set.
module uart_tx_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input logic               clk,
   input logic               rst,
   uart_tx_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t           state_r;
   logic [IDX_W-1:0] last_r;
   logic [NREQ-1:0]  ack_r;
   logic             grant_valid_r;
   logic [IDX_W-1:0] grant_idx_r;
   logic [7:0]       uart_byte_r;
   logic             uart_we_r;
   logic [NREQ-1:0]  eligible_s;
   logic [IDX_W-1:0] rr_idx_s;
   logic             rr_found_s;
   logic [IDX_W-1:0] winner_s;
   logic             found_s;
`ifdef UART_ARB_LOCK_EN
   logic             lock_hold_r;
`endif

   function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NREQ-1:0] v;
      v = {NREQ{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   assign bus.ack         = ack_r;
   assign bus.grant_valid = grant_valid_r;
   assign bus.grant_idx   = grant_idx_r;
   assign bus.uart_byte   = uart_byte_r;
   assign bus.uart_we     = uart_we_r;

   // Rotating search: first eligible requester after last, wrapping modulo NREQ.
   always_comb begin
      eligible_s = bus.req & ~ack_r;
      rr_idx_s   = last_r;
      rr_found_s = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!rr_found_s && eligible_s[(int'(last_r) + i) % NREQ]) begin
            rr_idx_s   = IDX_W'((int'(last_r) + i) % NREQ);
            rr_found_s = 1'b1;
         end else begin
            rr_found_s = rr_found_s;
         end
      end
   end

   // Winner selection; a held lock pins the grant to the previous owner while it still requests.
   always_comb begin
      winner_s = rr_idx_s;
      found_s  = rr_found_s;
`ifdef UART_ARB_LOCK_EN
      if (lock_hold_r && bus.req[grant_idx_r]) begin
         winner_s = grant_idx_r;
         found_s  = eligible_s[grant_idx_r];
      end else begin
         winner_s = rr_idx_s;
      end
`endif
   end

   // Grant/issue/track FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= IDLE;
         last_r        <= IDX_W'(NREQ - 1);
         ack_r         <= {NREQ{1'b0}};
         grant_valid_r <= 1'b0;
         grant_idx_r   <= {IDX_W{1'b0}};
         uart_byte_r   <= 8'h00;
         uart_we_r     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
         lock_hold_r   <= 1'b0;
`endif
      end else begin
         ack_r     <= {NREQ{1'b0}};
         uart_we_r <= 1'b0;
         case (state_r)
            IDLE: begin
`ifdef UART_ARB_LOCK_EN
               if (lock_hold_r && !bus.req[grant_idx_r]) begin
                  lock_hold_r <= 1'b0;
               end else begin
                  lock_hold_r <= lock_hold_r;
               end
`endif
               if (found_s) begin
                  grant_idx_r   <= winner_s;
                  uart_byte_r   <= bus.req_data[{winner_s, 3'b000} +: 8];
                  grant_valid_r <= 1'b1;
                  uart_we_r     <= 1'b1;
                  state_r       <= ISSUE;
               end else begin
                  state_r <= IDLE;
               end
            end
            ISSUE: begin
               state_r <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (bus.uart_busy) begin
                  state_r <= WAIT_DONE;
               end else begin
                  state_r <= WAIT_BUSY;
               end
            end
            WAIT_DONE: begin
               if (!bus.uart_busy) begin
                  ack_r         <= onehot(grant_idx_r);
                  grant_valid_r <= 1'b0;
                  state_r       <= IDLE;
`ifdef UART_ARB_LOCK_EN
                  lock_hold_r   <= bus.lock[grant_idx_r];
                  if (!bus.lock[grant_idx_r]) begin
                     last_r <= grant_idx_r;
                  end else begin
                     last_r <= last_r;
                  end
`else
                  last_r        <= grant_idx_r;
`endif
               end else begin
                  state_r <= WAIT_DONE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// transactions predicted by a round-robin reference model.
module tb_uart_tx_arbiter;
   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NREQ(NREQ), .IDX_W(IDX_W)) bus ();

   uart_tx_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef UART_ARB_LOCK_EN
   initial bus.lock = '0;
`endif

   int total = 0;
   int bad   = 0;
   int model_last;
   logic [NREQ-1:0]   req_v;
   logic [8*NREQ-1:0] data_v;
   logic [8*NREQ-1:0] mid_data;
   bit                mid_en = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference arbitration: first requesting index after the last winner, wrapping.
   function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (m[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] oh(input int idx);
      logic [NREQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   task automatic apply();
      bus.req      = req_v;
      bus.req_data = data_v;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.uart_busy = 1'b0;
      req_v = '0;
      data_v = '0;
      apply();
      repeat (3) @(negedge clk);
      check_val("reset_outputs", {bus.ack, bus.grant_valid, bus.grant_idx, bus.uart_byte, bus.uart_we}, 32'h0);
      rst = 1'b1;
      model_last = NREQ - 1;
   endtask

   // One full transaction as seen from uart_ctrl; returns cycles from call to write strobe.
   task automatic do_txn(input int exp_idx, input logic [7:0] exp_byte, input int busy_len, output int lat);
      int n;
      @(negedge clk);
      check_val("ack_one_cycle", bus.ack, 32'h0);
      n = 1;
      while (bus.uart_we !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      check_val("we_seen", bus.uart_we, 32'h1);
      check_val("grant_byte", bus.uart_byte, exp_byte);
      check_val("grant_idx", bus.grant_idx, exp_idx);
      check_val("grant_valid", bus.grant_valid, 32'h1);
      @(negedge clk);
      check_val("we_single", bus.uart_we, 32'h0);
      bus.uart_busy = 1'b1;
      for (int i = 0; i < busy_len; i++) begin
         @(negedge clk);
         if (i == 1 && mid_en) bus.req_data = mid_data;
      end
      check_val("ack_early", bus.ack, 32'h0);
      check_val("byte_hold", bus.uart_byte, exp_byte);
      bus.uart_busy = 1'b0;
      @(negedge clk);
      check_val("ack_pulse", bus.ack, oh(exp_idx));
      check_val("valid_drop", bus.grant_valid, 32'h0);
      check_val("ack_idx", bus.grant_idx, exp_idx);
      model_last = exp_idx;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int e;
      int quiet;
      // Single requester, exact strobe latency and ack.
      do_reset();
      req_v = 4'b0001;
      data_v[7:0] = 8'h69;
      apply();
      do_txn(0, 8'h69, 10, lat);
      check_val("first_latency", lat, 32'd1);
      req_v = '0;
      apply();

      // All requesting: strict rotation from a fresh reset.
      do_reset();
      data_v = 32'h13121110;
      req_v = 4'b1111;
      apply();
      for (int k = 0; k < 5; k++) begin
         do_txn(k % NREQ, 8'h10 + 8'(k % NREQ), 5, lat);
      end

      // last is 0 now: requester 2 wins before 0, then drops out.
      req_v = 4'b0101;
      apply();
      do_txn(2, 8'h12, 4, lat);
      req_v = 4'b0001;
      apply();
      do_txn(0, 8'h10, 4, lat);
      req_v = '0;
      apply();
      quiet = 0;
      repeat (5) begin
         @(negedge clk);
         quiet = quiet | int'(bus.uart_we) | int'(bus.grant_valid);
      end
      check_val("idle_quiet", quiet, 32'h0);

      // Data changed while the frame is in flight is only picked up by the next grant.
      req_v = 4'b0001;
      data_v[7:0] = 8'h41;
      apply();
      mid_data = data_v;
      mid_data[7:0] = 8'h42;
      mid_en = 1'b1;
      do_txn(0, 8'h41, 6, lat);
      mid_en = 1'b0;
      data_v = mid_data;
      do_txn(0, 8'h42, 4, lat);
      req_v = '0;
      apply();

      // Reset in the middle of a frame: outputs clear at once, no ack, fresh grant after.
      @(negedge clk);
      req_v = 4'b0001;
      data_v[7:0] = 8'h5A;
      apply();
      e = 0;
      while (bus.uart_we !== 1'b1 && e < 10) begin
         @(negedge clk);
         e++;
      end
      check_val("rst_txn_we", bus.uart_we, 32'h1);
      bus.uart_busy = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("async_reset_out", {bus.ack, bus.grant_valid, bus.grant_idx, bus.uart_byte, bus.uart_we}, 32'h0);
      bus.uart_busy = 1'b0;
      quiet = 0;
      repeat (3) begin
         @(negedge clk);
         quiet = quiet | int'(bus.ack);
      end
      check_val("no_ack_in_reset", quiet, 32'h0);
      rst = 1'b1;
      model_last = NREQ - 1;
      do_txn(0, 8'h5A, 4, lat);
      check_val("post_reset_latency", lat, 32'd1);

      // Randomized traffic against the reference model.
      for (int it = 0; it < 40; it++) begin
         req_v = 4'($urandom_range(1, 15));
         for (int k = 0; k < NREQ; k++) data_v[8*k +: 8] = 8'($urandom);
         apply();
         if ($urandom_range(0, 3) == 0) bus.uart_busy = 1'b1;
         mid_en = ($urandom_range(0, 1) == 1);
         for (int k = 0; k < NREQ; k++) mid_data[8*k +: 8] = 8'($urandom);
         e = rr_pick(req_v, model_last);
         do_txn(e, data_v[8*e +: 8], $urandom_range(3, 8), lat);
         if (mid_en) data_v = mid_data;
         mid_en = 1'b0;
      end
      req_v = '0;
      apply();
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
